// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single shared memory bus.
// Round-robin on ties, one outstanding transaction at a time, sticky timeout error.
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_i,
    output logic          stall_d,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [7:0] TMO_C = 8'(TMO);

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    logic          i_elig;
    logic          d_elig;
    logic          pick_d;
    logic [7:0]    cnt_inc;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;

        // A port still showing its done pulse is not eligible, so the finished
        // requester cannot be re-granted on the stale request it is still holding.
        i_elig  = i_req & ~i_done_q;
        d_elig  = d_req & ~d_done_q;
        pick_d  = d_elig & (~i_elig | ~last_d_q);
        cnt_inc = cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (i_elig | d_elig) begin
                    state_d     = pick_d ? GRANT_D : GRANT_I;
                    last_d_d    = pick_d;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_d & d_we;
                    mem_addr_d  = pick_d ? d_addr : i_addr;
                    mem_wdata_d = pick_d ? d_wdata : '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        if (state_q == GRANT_I) begin
                            i_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    mem_req_d = 1'b0;
                    i_done_d  = (state_q == GRANT_I);
                    d_done_d  = (state_q == GRANT_D);
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    // Abort: requester still gets its done pulse so it can retire.
                    if (cnt_inc == TMO_C) begin
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        i_done_d  = (state_q == GRANT_I);
                        d_done_d  = (state_q == GRANT_D);
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign stall_i   = i_req & ~i_done_q;
    assign stall_d   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model (memory array + round-robin rule).
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          stall_i;
    logic          stall_d;
    logic          err;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_i(stall_i), .stall_d(stall_d), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, expected visible results, current transaction.
    logic [DW-1:0] mem_model [16];
    logic [DW-1:0] exp_i_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;
    logic          exp_err = 1'b0;
    int            last_d = 0;       // 1 when data port was granted most recently
    int            inflight = 0;     // 0 none, 1 fetch, 2 data
    int            exp_grant = 0;    // grant expected to be visible at next sample
    int            exp_done = 0;     // done expected to be visible at next sample
    logic [AW-1:0] g_addr = '0;
    logic          g_we = 1'b0;
    logic [DW-1:0] g_wdata = '0;
    int            req_cycles = 0;
    int            ack_delay = 0;
    int            force_delay = -1;
    bit            no_ack = 1'b0;
    bit            cur_noack = 1'b0;
    int            noack_pct = 0;
    int            p_issue = 0;
    bit            i_pend = 1'b0;
    bit            d_pend = 1'b0;
    bit            stray = 1'b0;
    int            done_log [$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int log_at(input int i);
        if (i < 0 || i >= done_log.size()) return -1;
        return done_log[i];
    endfunction

    // Winner of the next arbitration, from the requests the DUT will see at the next edge.
    task automatic predict();
        bit ei, ed;
        int w;
        if (inflight != 0) return;
        exp_grant = 0;
        ei = i_req && !i_done;
        ed = d_req && !d_done;
        if (ei && ed) w = (last_d != 0) ? 1 : 2;
        else if (ed)  w = 2;
        else if (ei)  w = 1;
        else          w = 0;
        if (w == 2) begin
            exp_grant = 2; g_addr = d_addr; g_we = d_we; g_wdata = d_wdata;
        end else if (w == 1) begin
            exp_grant = 1; g_addr = i_addr; g_we = 1'b0; g_wdata = '0;
        end
    endtask

    task automatic model_reset();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_err     = 1'b0;
        last_d      = 0;
        inflight    = 0;
        exp_done    = 0;
        exp_grant   = 0;
    endtask

    task automatic step();
        int dp;
        logic [3:0] idx;
        @(posedge clk);
        #1;
        dp = exp_done;
        exp_done = 0;
        chk1("i_done", i_done, dp == 1);
        chk1("d_done", d_done, dp == 2);
        if (i_done) done_log.push_back(1);
        if (d_done) done_log.push_back(2);
        if (dp != 0) inflight = 0;
        if (exp_grant != 0) begin
            chk1("grant_req", mem_req, 1'b1);
            chk32("grant_addr", mem_addr, g_addr);
            chk1("grant_we", mem_we, g_we);
            chk32("grant_wdata", mem_wdata, g_wdata);
            inflight   = exp_grant;
            last_d     = (exp_grant == 2) ? 1 : 0;
            req_cycles = 0;
            ack_delay  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, TMO - 1));
            cur_noack  = no_ack || (int'($urandom_range(0, 99)) < noack_pct);
            exp_grant  = 0;
        end else if (inflight != 0) begin
            chk1("busy_req", mem_req, 1'b1);
            chk32("busy_addr", mem_addr, g_addr);
            chk1("busy_we", mem_we, g_we);
            chk32("busy_wdata", mem_wdata, g_wdata);
        end else begin
            chk1("idle_req", mem_req, 1'b0);
        end
        chk32("i_rdata", i_rdata, exp_i_rdata);
        chk32("d_rdata", d_rdata, exp_d_rdata);
        chk1("err", err, exp_err);
        chk1("stall_i", stall_i, i_req & ~i_done);
        chk1("stall_d", stall_d, d_req & ~d_done);

        // Memory responder
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (inflight != 0) begin
            req_cycles++;
            if (!cur_noack && (req_cycles - 1) == ack_delay) begin
                mem_ack = 1'b1;
                idx = g_addr[5:2];
                if (g_we) begin
                    mem_model[idx] = g_wdata;
                end else begin
                    mem_rdata = mem_model[idx];
                    if (inflight == 1) exp_i_rdata = mem_rdata;
                    else               exp_d_rdata = mem_rdata;
                end
                exp_done = inflight;
            end else if (req_cycles == TMO) begin
                exp_done = inflight;
                exp_err  = 1'b1;
            end
        end else if (stray) begin
            mem_ack = 1'b1;
            stray   = 1'b0;
        end

        // Requesters react to the DUT's own done pulses
        if (i_done) i_pend = 1'b0;
        if (d_done) d_pend = 1'b0;
        if (!i_pend && int'($urandom_range(0, 99)) < p_issue) begin
            i_pend = 1'b1;
            i_addr = $urandom;
        end
        if (!d_pend && int'($urandom_range(0, 99)) < p_issue) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        i_req = i_pend;
        d_req = d_pend;
        predict();
    endtask

    task automatic issue_i(input logic [AW-1:0] a);
        i_pend = 1'b1; i_req = 1'b1; i_addr = a;
        predict();
    endtask

    task automatic issue_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_pend = 1'b1; d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        predict();
    endtask

    task automatic run_txns(input int n, input int budget);
        int target;
        int cyc;
        target = done_log.size() + n;
        cyc = 0;
        while (done_log.size() < target && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        assert (done_log.size() >= target) else begin
            errors++;
            $error("FAIL wait_done: observed %0d done pulses, required %0d within %0d cycles",
                   done_log.size() - (target - n), n, budget);
        end
    endtask

    task automatic drain(input int budget);
        int cyc;
        cyc = 0;
        while ((i_pend || d_pend) && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        assert (!i_pend && !d_pend) else begin
            errors++;
            $error("FAIL drain: requests still pending i=%0d d=%0d, required none", i_pend, d_pend);
        end
    endtask

    // Reset is applied pre time units after the current sample point, i.e. off the clock edge.
    task automatic do_reset(input int pre);
        if (pre > 0) #(pre);
        reset   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_i_done", i_done, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk32("rst_i_rdata", i_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_err", err, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        chk1("rst_hold_req", mem_req, 1'b0);
        reset = 1'b1;
        predict();
    endtask

    initial begin
        int s;
        int cyc;
        for (int k = 0; k < 16; k++) mem_model[k] = $urandom;
        mem_model[0] = 32'h8C020004;

        // Power-on reset
        #1;
        do_reset(0);

        // Single fetch with ack two cycles after mem_req
        force_delay = 2;
        issue_i(32'h40);
        run_txns(1, 20);
        chk32("fetch_rdata", i_rdata, 32'h8C020004);
        force_delay = -1;

        // Simultaneous requests right after reset: data wins the first tie
        do_reset(0);
        s = done_log.size();
        issue_i(32'h80);
        issue_d(1'b1, 32'h10, 32'h0000DEAD);
        run_txns(2, 40);
        chk32("simul_first", 32'(log_at(s)), 32'd2);
        chk32("simul_second", 32'(log_at(s + 1)), 32'd1);
        chk32("simul_d_rdata", d_rdata, 32'h0);

        // Round-robin with both ports requesting continuously
        s = done_log.size();
        p_issue = 100;
        issue_i($urandom);
        issue_d(1'($urandom_range(0, 1)), $urandom, $urandom);
        run_txns(4, 60);
        p_issue = 0;
        drain(60);
        chk32("rr_0", 32'(log_at(s)), 32'd2);
        chk32("rr_1", 32'(log_at(s + 1)), 32'd1);
        chk32("rr_2", 32'(log_at(s + 2)), 32'd2);
        chk32("rr_3", 32'(log_at(s + 3)), 32'd1);

        // Timeout on a data read that is never acknowledged
        no_ack = 1'b1;
        issue_d(1'b0, 32'h20, 32'h0);
        run_txns(1, 20);
        no_ack = 1'b0;
        chk1("tmo_err", err, 1'b1);
        issue_i(32'h44);
        run_txns(1, 20);
        chk1("tmo_err_sticky", err, 1'b1);

        // Reset while a fetch is on the bus; held request must be granted again
        no_ack = 1'b1;
        issue_i(32'h48);
        cyc = 0;
        while (inflight == 0 && cyc < 5) begin
            step();
            cyc++;
        end
        chk1("mid_busy", mem_req, 1'b1);
        do_reset(2);
        no_ack = 1'b0;
        run_txns(1, 20);
        chk1("mid_err_cleared", err, 1'b0);

        // Stray ack while idle, then a normal read
        stray = 1'b1;
        step();
        step();
        chk1("stray_no_i_done", i_done, 1'b0);
        chk1("stray_no_d_done", d_done, 1'b0);
        issue_d(1'b0, 32'h40, 32'h0);
        run_txns(1, 20);
        chk32("stray_then_read", d_rdata, 32'h8C020004);

        // Random traffic, including occasional timeouts and boundary ack delays
        p_issue = 40;
        noack_pct = 5;
        repeat (3000) step();
        p_issue = 0;
        noack_pct = 0;
        drain(100);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- AW, default 32, address width.
- DW, default 32, data width.
- TMO, default 255, cycles without mem_ack before abort (1..255).
REQ-002 Ports SHALL be:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch request, held until i_done.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetch read data.
- i_done  out  1  fetch complete, one-cycle pulse.
- d_req  in  1  data request, held until d_done.
- d_we  in  1  data write (1) or read (0).
- d_addr  in  AW  data address.
- d_wdata  in  DW  data write value.
- d_rdata  out  DW  data read data.
- d_done  out  1  data complete, one-cycle pulse.
- mem_req  out  1  shared-memory request.
- mem_we  out  1  shared-memory write enable.
- mem_addr  out  AW  shared-memory address.
- mem_wdata  out  DW  shared-memory write data.
- mem_rdata  in  DW  shared-memory read data, valid with mem_ack.
- mem_ack  in  1  shared-memory completion, one-cycle pulse.
- stall_i  out  1  freeze fetch stage.
- stall_d  out  1  freeze memory stage.
- err  out  1  sticky timeout flag.

Function
REQ-003 FSM states SHALL be IDLE, GRANT_I, GRANT_D.
REQ-004 Arbitration SHALL happen only in IDLE. A port is eligible when its req=1 and its done=0 in that cycle.
REQ-005 If one port is eligible, it SHALL be granted. If both are eligible, the port not granted last SHALL win (round-robin). Last-grant SHALL reset to I, so data wins the first tie.
REQ-006 At the grant edge, the block SHALL register mem_addr, mem_we and mem_wdata from the winner. For the I port, mem_we=0 and mem_wdata=0. mem_req SHALL rise in the cycle after the grant decision.
REQ-007 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable in GRANT_x until mem_ack. Requester input changes during GRANT_x SHALL be ignored.
REQ-008 On mem_ack in GRANT_x:
- Capture mem_rdata into x_rdata (reads only; writes leave d_rdata unchanged).
- Drop mem_req at the next edge.
- Pulse x_done for exactly one cycle, in the cycle after mem_ack.
- Return to IDLE.
REQ-009 x_rdata SHALL hold its value until the next completed read on that port.
REQ-010 Minimum latency SHALL be:
- Request sampled in IDLE at edge N.
- mem_req=1 from N+1.
- mem_ack at cycle N+1+k.
- done at N+2+k.
- The next grant can be decided in the done cycle, so mem_req is low for exactly one cycle between back-to-back transactions.
REQ-011 mem_ack in IDLE SHALL be ignored, with no state, data or done change.
REQ-012 stall_i SHALL equal i_req & ~i_done, and stall_d SHALL equal d_req & ~d_done, both combinational.
REQ-013 An 8-bit wait counter SHALL clear at grant and increment each GRANT_x cycle without mem_ack.
REQ-014 When the counter reaches TMO, the block SHALL:
- Set err (sticky).
- Drop mem_req.
- Pulse x_done with x_rdata unchanged.
- Return to IDLE.
REQ-015 mem_ack in the same cycle the counter reaches TMO SHALL count as a normal completion, with no err.
REQ-016 err SHALL clear only on reset.

Reset
REQ-017 reset=0 SHALL immediately force:
- State IDLE, last-grant I, counter 0.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- i_done=0, d_done=0, i_rdata=0, d_rdata=0, err=0.
This applies regardless of the clock, including mid-transaction.
REQ-018 After reset deasserts, the first arbitration SHALL happen at the first rising edge with reset=1. An aborted transaction SHALL NOT produce a done pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single fetch: i_req, i_addr=0x40, ack 2 cycles after mem_req with mem_rdata=0x8C020004 -> mem_we=0, mem_addr=0x40, i_done one cycle after ack, i_rdata=0x8C020004, stall_i=1 until the done cycle.
- Simultaneous requests after reset: i_req and d_req (d_we=1, d_addr=0x10, d_wdata=0xDEAD) -> data served first, mem_we=1; fetch next, mem_req low exactly one cycle between; d_rdata stays 0.
- Round-robin: both requests held continuously for 4 transactions -> grant order D, I, D, I.
- Timeout: TMO=4, d_req read, mem_ack never asserted -> mem_req drops after 4 wait cycles, d_done pulses, err=1 and stays 1 across further transactions.
- Mid-transaction reset: reset=0 while mem_req=1 -> mem_req=0 with no clock edge, no done pulse; after release, the pending held request is re-granted.
- Stray ack: mem_ack pulse in IDLE -> no done, rdata and state unchanged.
